// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one single-port memory between the CPU port and a
//               DMA/debug-loader port. One transaction in flight at a time:
//               grant, one-cycle strobe, optional read-latency wait, then a
//               one-cycle ack to the winning requester.
// Ports       : i_clk, i_rst_n         clock, async active-low reset
//               i_cpu_* / o_cpu_*      CPU request side (req/wr/address/data,
//                                      read data, ack)
//               i_dma_* / o_dma_*      DMA request side, same shape
//               o_mem_rd/o_mem_wr      memory strobes
//               o_mem_address/_data    memory address and write data
//               i_mem_data             memory read data
//               o_grant                one-hot owner {dma,cpu}, 00 when idle
//               o_busy                 high whenever a transaction is active
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int RD_LATENCY   = 1,
   parameter int CPU_PRIORITY = 0
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_cpu_req,
   input  logic          i_cpu_wr,
   input  logic [AW-1:0] i_cpu_address,
   input  logic [DW-1:0] i_cpu_data,
   output logic [DW-1:0] o_cpu_data,
   output logic          o_cpu_ack,
   input  logic          i_dma_req,
   input  logic          i_dma_wr,
   input  logic [AW-1:0] i_dma_address,
   input  logic [DW-1:0] i_dma_data,
   output logic [DW-1:0] o_dma_data,
   output logic          o_dma_ack,
   output logic          o_mem_rd,
   output logic          o_mem_wr,
   output logic [AW-1:0] o_mem_address,
   output logic [DW-1:0] o_mem_data,
   input  logic [DW-1:0] i_mem_data,
   output logic [1:0]    o_grant,
   output logic          o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   // Read latency is limited to 0..7, so a 3-bit down-counter suffices.
   localparam logic [2:0] LAT = 3'(RD_LATENCY);

   state_t          state_q;
   logic [2:0]      cnt_q;
   logic            op_wr_q;
   logic            last_dma_q;
   logic            mem_rd_q;
   logic            mem_wr_q;
   logic [AW-1:0]   mem_address_q;
   logic [DW-1:0]   mem_data_q;
   logic            cpu_ack_q;
   logic            dma_ack_q;
   logic [DW-1:0]   cpu_data_q;
   logic [DW-1:0]   dma_data_q;
   logic [1:0]      grant_q;
   logic            busy_q;

   logic            pick_dma_d;
   logic            done_d;

   // Winner selection. On a tie with round-robin enabled the port that did
   // not win last time is chosen; last_dma_q resets to 1 so the first tie
   // after reset goes to the CPU.
   always_comb begin
      pick_dma_d = 1'b0;
      if (i_dma_req && !i_cpu_req) begin
         pick_dma_d = 1'b1;
      end else if (i_dma_req && i_cpu_req && (CPU_PRIORITY == 0)) begin
         pick_dma_d = !last_dma_q;
      end
   end

   // High in the final ISSUE/WAIT cycle: the next edge enters ACK and
   // samples the memory read data.
   always_comb begin
      done_d = ((state_q == S_ISSUE) && (op_wr_q || (LAT == 3'd0))) ||
               ((state_q == S_WAIT)  && (cnt_q == 3'd1));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= 3'd0;
         op_wr_q       <= 1'b0;
         last_dma_q    <= 1'b1;
         mem_rd_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         cpu_ack_q     <= 1'b0;
         dma_ack_q     <= 1'b0;
         cpu_data_q    <= '0;
         dma_data_q    <= '0;
         grant_q       <= 2'b00;
         busy_q        <= 1'b0;
      end else begin
         // Strobes and acks are single-cycle pulses.
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               if (i_cpu_req || i_dma_req) begin
                  grant_q       <= pick_dma_d ? 2'b10 : 2'b01;
                  last_dma_q    <= pick_dma_d;
                  op_wr_q       <= pick_dma_d ? i_dma_wr      : i_cpu_wr;
                  mem_address_q <= pick_dma_d ? i_dma_address : i_cpu_address;
                  mem_data_q    <= pick_dma_d ? i_dma_data    : i_cpu_data;
                  if (pick_dma_d ? i_dma_wr : i_cpu_wr) begin
                     mem_wr_q <= 1'b1;
                  end else begin
                     mem_rd_q <= 1'b1;
                  end
                  busy_q  <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (done_d) begin
                  state_q <= S_ACK;
               end else begin
                  cnt_q   <= LAT;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 3'd1;
               if (done_d) begin
                  state_q <= S_ACK;
               end
            end
            S_ACK: begin
               grant_q <= 2'b00;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase

         if (done_d) begin
            cpu_ack_q <= grant_q[0];
            dma_ack_q <= grant_q[1];
            if (!op_wr_q) begin
               if (grant_q[0]) begin
                  cpu_data_q <= i_mem_data;
               end
               if (grant_q[1]) begin
                  dma_data_q <= i_mem_data;
               end
            end
         end
      end
   end

   assign o_mem_rd      = mem_rd_q;
   assign o_mem_wr      = mem_wr_q;
   assign o_mem_address = mem_address_q;
   assign o_mem_data    = mem_data_q;
   assign o_cpu_ack     = cpu_ack_q;
   assign o_dma_ack     = dma_ack_q;
   assign o_cpu_data    = cpu_data_q;
   assign o_dma_data    = dma_data_q;
   assign o_grant       = grant_q;
   assign o_busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed self-checking bench for mem_bus_arbiter. Three
//               instances with different parameters, each with its own
//               small memory model that only presents valid read data in
//               the cycle the configured latency says it should.
//                 inst 0 : RD_LATENCY=1, round-robin
//                 inst 1 : RD_LATENCY=3, CPU priority
//                 inst 2 : RD_LATENCY=0, round-robin
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst_n;

   logic        cpu_req   [3];
   logic        dma_req   [3];
   logic        cpu_wr;
   logic [15:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        dma_wr;
   logic [15:0] dma_addr;
   logic [15:0] dma_wdata;

   logic [15:0] cpu_rdata [3];
   logic [15:0] dma_rdata [3];
   logic        cpu_ack   [3];
   logic        dma_ack   [3];
   logic        mem_rd    [3];
   logic        mem_wr    [3];
   logic [15:0] mem_addr  [3];
   logic [15:0] mem_wdata [3];
   logic [15:0] mem_rdata [3];
   logic [1:0]  grant     [3];
   logic        busy      [3];

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int LAT = (gi == 1) ? 3 : ((gi == 2) ? 0 : 1);
      localparam int PRI = (gi == 1) ? 1 : 0;

      logic [15:0] mem [0:1023];
      logic [3:0]  age_q;
      logic        pend_q;
      logic [3:0]  age_now;

      mem_bus_arbiter #(
         .AW(16), .DW(16), .RD_LATENCY(LAT), .CPU_PRIORITY(PRI)
      ) u_dut (
         .i_clk         (clk),
         .i_rst_n       (rst_n),
         .i_cpu_req     (cpu_req[gi]),
         .i_cpu_wr      (cpu_wr),
         .i_cpu_address (cpu_addr),
         .i_cpu_data    (cpu_wdata),
         .o_cpu_data    (cpu_rdata[gi]),
         .o_cpu_ack     (cpu_ack[gi]),
         .i_dma_req     (dma_req[gi]),
         .i_dma_wr      (dma_wr),
         .i_dma_address (dma_addr),
         .i_dma_data    (dma_wdata),
         .o_dma_data    (dma_rdata[gi]),
         .o_dma_ack     (dma_ack[gi]),
         .o_mem_rd      (mem_rd[gi]),
         .o_mem_wr      (mem_wr[gi]),
         .o_mem_address (mem_addr[gi]),
         .o_mem_data    (mem_wdata[gi]),
         .i_mem_data    (mem_rdata[gi]),
         .o_grant       (grant[gi]),
         .o_busy        (busy[gi])
      );

      // Memory model: age counts cycles since the last read strobe (0 in
      // the strobe cycle). Data is valid only when age equals the latency.
      always @(posedge clk) begin
         if (!rst_n) begin
            pend_q         <= 1'b0;
            age_q          <= 4'd0;
            mem[10'h3FF]   <= 16'hBEEF;
         end else begin
            if (mem_wr[gi]) mem[mem_addr[gi][9:0]] <= mem_wdata[gi];
            if (mem_rd[gi]) begin
               pend_q <= 1'b1;
               age_q  <= 4'd1;
            end else if (pend_q && age_q != 4'd15) begin
               age_q <= age_q + 4'd1;
            end
         end
      end

      assign age_now       = mem_rd[gi] ? 4'd0 : age_q;
      assign mem_rdata[gi] = ((mem_rd[gi] || pend_q) && (age_now == 4'(LAT)))
                             ? mem[mem_addr[gi][9:0]] : 16'hDEAD;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
   endtask

   task automatic wait_idle(input int idx);
      int n = 0;
      while (busy[idx] !== 1'b0 && n < 20) begin
         step();
         n++;
      end
      chk("idle_timeout", 32'(busy[idx]), 32'd0);
   endtask

   initial begin
      int dma_acks;
      rst_n     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cpu_req[i] = 1'b0;
         dma_req[i] = 1'b0;
      end
      cpu_wr    = 1'b1;
      cpu_addr  = 16'h0100;
      cpu_wdata = 16'h0BAD;
      dma_wr    = 1'b1;
      dma_addr  = 16'h0200;
      dma_wdata = 16'h0BAD;

      // ---- 1: reset with both requests high -------------------------------
      cpu_req[0] = 1'b1;
      dma_req[0] = 1'b1;
      step(); step(); step();
      chk("rst_grant",  32'(grant[0]),     32'd0);
      chk("rst_busy",   32'(busy[0]),      32'd0);
      chk("rst_mem_wr", 32'(mem_wr[0]),    32'd0);
      chk("rst_mem_rd", 32'(mem_rd[0]),    32'd0);
      chk("rst_ack",    32'({cpu_ack[0], dma_ack[0]}), 32'd0);
      chk("rst_addr",   32'(mem_addr[0]),  32'd0);
      chk("rst_rdata",  32'(cpu_rdata[0]), 32'd0);
      rst_n = 1'b1;
      step();
      chk("first_grant_cpu", 32'(grant[0]),    32'h1);
      chk("first_wr",        32'(mem_wr[0]),   32'd1);
      chk("first_addr",      32'(mem_addr[0]), 32'h0100);
      cpu_req[0] = 1'b0;
      dma_req[0] = 1'b0;
      wait_idle(0);

      // ---- 2: CPU write then read back -------------------------------------
      cpu_req[0] = 1'b1;
      cpu_wr     = 1'b1;
      cpu_addr   = 16'h0010;
      cpu_wdata  = 16'h1234;
      step();
      chk("wr_strobe", 32'(mem_wr[0]),    32'd1);
      chk("wr_no_rd",  32'(mem_rd[0]),    32'd0);
      chk("wr_addr",   32'(mem_addr[0]),  32'h0010);
      chk("wr_data",   32'(mem_wdata[0]), 32'h1234);
      chk("wr_no_ack", 32'(cpu_ack[0]),   32'd0);
      step();
      chk("wr_strobe_off", 32'(mem_wr[0]),  32'd0);
      chk("wr_ack",        32'(cpu_ack[0]), 32'd1);
      cpu_req[0] = 1'b0;
      step();
      chk("wr_ack_off", 32'(cpu_ack[0]), 32'd0);
      chk("wr_idle",    32'(busy[0]),    32'd0);
      cpu_req[0] = 1'b1;
      cpu_wr     = 1'b0;
      step();
      chk("rd_strobe", 32'(mem_rd[0]), 32'd1);
      step();
      chk("rd_strobe_off", 32'(mem_rd[0]),  32'd0);
      chk("rd_wait_noack", 32'(cpu_ack[0]), 32'd0);
      step();
      chk("rd_ack",   32'(cpu_ack[0]),   32'd1);
      chk("rd_data",  32'(cpu_rdata[0]), 32'h1234);
      cpu_req[0] = 1'b0;
      step();
      chk("rd_ack_off",   32'(cpu_ack[0]),   32'd0);
      chk("rd_data_hold", 32'(cpu_rdata[0]), 32'h1234);

      // ---- 3: continuous tie, round-robin (inst 0) and priority (inst 1) ---
      cpu_wr     = 1'b1;
      cpu_addr   = 16'h0011;
      cpu_wdata  = 16'h1111;
      dma_wr     = 1'b1;
      dma_addr   = 16'h0020;
      dma_wdata  = 16'h5555;
      cpu_req[0] = 1'b1;
      dma_req[0] = 1'b1;
      cpu_req[1] = 1'b1;
      dma_req[1] = 1'b1;
      dma_acks   = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (dma_ack[1]) dma_acks++;
         chk("no_overlap", 32'(mem_rd[0] & mem_wr[0]), 32'd0);
         if (k % 3 == 1) begin
            // Last grant before this burst was CPU, so the DMA leads.
            chk("rr_grant",  32'(grant[0]),    ((k % 6) == 1) ? 32'h2 : 32'h1);
            chk("rr_addr",   32'(mem_addr[0]), ((k % 6) == 1) ? 32'h0020 : 32'h0011);
            chk("pri_grant", 32'(grant[1]),    32'h1);
         end
      end
      chk("pri_dma_acks", 32'(dma_acks), 32'd0);
      cpu_req[0] = 1'b0;
      dma_req[0] = 1'b0;
      cpu_req[1] = 1'b0;
      dma_req[1] = 1'b0;
      wait_idle(0);
      wait_idle(1);

      // ---- 4: DMA request during CPU read wait ----------------------------
      cpu_req[0] = 1'b1;
      cpu_wr     = 1'b0;
      cpu_addr   = 16'h0011;
      step();
      chk("q_cpu_rd", 32'(mem_rd[0]), 32'd1);
      step();
      dma_req[0] = 1'b1;
      dma_wr     = 1'b1;
      dma_addr   = 16'h0030;
      dma_wdata  = 16'hA5A5;
      step();
      chk("q_cpu_ack",   32'(cpu_ack[0]),   32'd1);
      chk("q_cpu_data",  32'(cpu_rdata[0]), 32'h1111);
      chk("q_no_wr_ack", 32'(mem_wr[0]),    32'd0);
      cpu_req[0] = 1'b0;
      step();
      chk("q_idle_wr",    32'(mem_wr[0]), 32'd0);
      chk("q_idle_grant", 32'(grant[0]),  32'd0);
      step();
      chk("q_dma_wr",    32'(mem_wr[0]),   32'd1);
      chk("q_dma_no_rd", 32'(mem_rd[0]),   32'd0);
      chk("q_dma_grant", 32'(grant[0]),    32'h2);
      chk("q_dma_addr",  32'(mem_addr[0]), 32'h0030);
      step();
      chk("q_dma_ack", 32'(dma_ack[0]), 32'd1);
      dma_req[0] = 1'b0;
      wait_idle(0);

      // ---- 5: reset during read wait ---------------------------------------
      cpu_req[0] = 1'b1;
      cpu_wr     = 1'b0;
      cpu_addr   = 16'h0010;
      step();
      step();
      chk("mr_in_wait", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy",  32'(busy[0]),      32'd0);
      chk("mr_grant", 32'(grant[0]),     32'd0);
      chk("mr_rd",    32'(mem_rd[0]),    32'd0);
      chk("mr_rdata", 32'(cpu_rdata[0]), 32'd0);
      cpu_req[0] = 1'b0;
      step();
      chk("mr_no_ack", 32'(cpu_ack[0]), 32'd0);
      rst_n      = 1'b1;
      cpu_req[0] = 1'b1;
      cpu_wr     = 1'b1;
      cpu_addr   = 16'h0040;
      cpu_wdata  = 16'hCAFE;
      step();
      chk("mr_wr",      32'(mem_wr[0]),    32'd1);
      chk("mr_wr_data", 32'(mem_wdata[0]), 32'hCAFE);
      step();
      chk("mr_wr_ack", 32'(cpu_ack[0]), 32'd1);
      cpu_req[0] = 1'b0;
      wait_idle(0);

      // ---- 6: DMA read of 0x03FF with latency 0 (inst 2) and 3 (inst 1) ----
      dma_wr     = 1'b0;
      dma_addr   = 16'h03FF;
      dma_req[1] = 1'b1;
      dma_req[2] = 1'b1;
      step();
      chk("l0_rd", 32'(mem_rd[2]), 32'd1);
      chk("l3_rd", 32'(mem_rd[1]), 32'd1);
      step();
      chk("l0_ack",    32'(dma_ack[2]),   32'd1);
      chk("l0_data",   32'(dma_rdata[2]), 32'hBEEF);
      chk("l3_noack2", 32'(dma_ack[1]),   32'd0);
      dma_req[2] = 1'b0;
      step();
      chk("l3_noack3", 32'(dma_ack[1]), 32'd0);
      step();
      chk("l3_noack4", 32'(dma_ack[1]), 32'd0);
      step();
      chk("l3_ack",  32'(dma_ack[1]),   32'd1);
      chk("l3_data", 32'(dma_rdata[1]), 32'hBEEF);
      dma_req[1] = 1'b0;
      step();
      chk("l3_ack_off", 32'(dma_ack[1]), 32'd0);
      wait_idle(1);
      wait_idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
